// File: rtl/lms_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared definitions for the ANC LMS core datapath:
//   - Q1.15 fractional bit count and sample/weight/product/IO widths
//   - sat16 / sat32 clamping helpers (take a wide signed value)
//   - engine state enum used by lms_fir_engine
// -----------------------------------------------------------------------------
package lms_pkg;

  localparam int FRAC  = 15;   // fractional bits of Q1.15 samples and weights
  localparam int SW    = 16;   // stored sample / weight width
  localparam int PW    = 32;   // product width
  localparam int DW    = 32;   // external data width
  localparam int WIDEW = 48;   // width of the saturation helpers' input

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } eng_state_e;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic logic signed [SW-1:0] sat16(input logic signed [WIDEW-1:0] v);
    if (v > 48'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -48'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[SW-1:0];
    end
  endfunction

  // Clamp a wide signed value into the 32-bit signed range.
  function automatic logic signed [DW-1:0] sat32(input logic signed [WIDEW-1:0] v);
    if (v > 48'sd2147483647) begin
      return 32'sh7FFF_FFFF;
    end else if (v < -48'sd2147483648) begin
      return 32'sh8000_0000;
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// -----------------------------------------------------------------------------
// lms_tap_mac
// Combinational per-tap datapath of the LMS FIR engine.
// Ports:
//   w_i      in  16 signed  current (old) weight of the selected tap
//   x_i      in  16 signed  delay-line sample of the selected tap
//   mu_e_i   in  16 signed  step-size * error term for this pass
//   prod_o   out 32 signed  w_i * x_i, contribution to the accumulator
//   w_upd_o  out 16 signed  sat16(w_i + ((mu_e_i * x_i) >>> FRAC))
// -----------------------------------------------------------------------------
module lms_tap_mac
  import lms_pkg::*;
(
  input  logic signed [SW-1:0] w_i,
  input  logic signed [SW-1:0] x_i,
  input  logic signed [SW-1:0] mu_e_i,
  output logic signed [PW-1:0] prod_o,
  output logic signed [SW-1:0] w_upd_o
);

  logic signed [PW-1:0]    w_ext;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    mu_ext;
  logic signed [PW-1:0]    upd_prod;
  logic signed [PW-1:0]    upd_sh;
  logic signed [WIDEW-1:0] w_sum;

  // 16x16 signed products always fit in 32 bits, so multiplying the
  // sign-extended operands at 32 bits is exact.
  assign w_ext    = {{(PW-SW){w_i[SW-1]}}, w_i};
  assign x_ext    = {{(PW-SW){x_i[SW-1]}}, x_i};
  assign mu_ext   = {{(PW-SW){mu_e_i[SW-1]}}, mu_e_i};

  assign prod_o   = w_ext * x_ext;
  assign upd_prod = mu_ext * x_ext;
  assign upd_sh   = upd_prod >>> FRAC;

  // Sum formed wide so the clamp sees the true value and the weight never wraps.
  assign w_sum    = {{(WIDEW-SW){w_i[SW-1]}}, w_i} + {{(WIDEW-PW){upd_sh[PW-1]}}, upd_sh};
  assign w_upd_o  = sat16(w_sum);

endmodule

// File: rtl/lms_fir_engine.sv
// -----------------------------------------------------------------------------
// lms_fir_engine
// Adaptive FIR engine of the ANC LMS core. One time-multiplexed pass per
// sample: each MAC cycle accumulates w[k]*x[k] with the old weight and, when
// adaptation is enabled, writes back the LMS-updated weight for that tap.
// Ports:
//   clk           in   1          clock, rising edge
//   rst_n         in   1          asynchronous active-low reset
//   fir_go        in   1          start pulse, honoured only in IDLE
//   sample_in     in  32 signed   new reference sample
//   weight_adjust in  32 signed   Q2.30 (error - desired)*u product
//   adapt_en      in   1          1 = update weights this pass
//   fir_out       out 32 signed   filter output, held between passes
//   fir_done      out  1          one-cycle pulse when fir_out is updated
//   busy          out  1          high while in MAC or DONE
// -----------------------------------------------------------------------------
module lms_fir_engine
  import lms_pkg::*;
#(
  parameter int NTAPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fir_go,
  input  logic signed [DW-1:0] sample_in,
  input  logic signed [DW-1:0] weight_adjust,
  input  logic                 adapt_en,
  output logic signed [DW-1:0] fir_out,
  output logic                 fir_done,
  output logic                 busy
);

  localparam int KW    = $clog2(NTAPS);
  // One guard bit beyond the log2 growth keeps the sum from ever wrapping.
  localparam int ACC_W = PW + $clog2(NTAPS) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

  eng_state_e state_q, state_d;

  logic signed [SW-1:0]    x_q [NTAPS];
  logic signed [SW-1:0]    w_q [NTAPS];
  logic signed [SW-1:0]    mu_e_q;
  logic                    adapt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [KW-1:0]           k_q;
  logic signed [DW-1:0]    fir_out_q;
  logic                    fir_done_q;

  logic signed [SW-1:0]    x_sel;
  logic signed [SW-1:0]    w_sel;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    w_upd;
  logic signed [WIDEW-1:0] sample_ext;
  logic signed [DW-1:0]    wa_sh;
  logic signed [WIDEW-1:0] wa_ext;
  logic signed [WIDEW-1:0] acc_ext;
  logic signed [WIDEW-1:0] acc_shift;
  logic                    accept;

  // ---------------------------------------------------------------------------
  // Tap selection and shared MAC / update datapath
  // ---------------------------------------------------------------------------
  assign x_sel = x_q[k_q];
  assign w_sel = w_q[k_q];

  lms_tap_mac u_tap_mac (
    .w_i     (w_sel),
    .x_i     (x_sel),
    .mu_e_i  (mu_e_q),
    .prod_o  (prod),
    .w_upd_o (w_upd)
  );

  assign accept     = (state_q == IDLE) && fir_go;
  assign sample_ext = {{(WIDEW-DW){sample_in[DW-1]}}, sample_in};
  assign wa_sh      = weight_adjust >>> FRAC;
  assign wa_ext     = {{(WIDEW-DW){wa_sh[DW-1]}}, wa_sh};
  assign acc_ext    = {{(WIDEW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign acc_shift  = acc_ext >>> FRAC;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fir_go) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Delay line, weights, accumulator and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      mu_e_q     <= '0;
      adapt_q    <= 1'b0;
      acc_q      <= '0;
      k_q        <= '0;
      fir_out_q  <= '0;
      fir_done_q <= 1'b0;
    end else begin
      fir_done_q <= 1'b0;
      if (accept) begin
        // Inputs are captured only here; later changes cannot affect the pass.
        x_q[0] <= sat16(sample_ext);
        for (int i = 1; i < NTAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
        mu_e_q  <= sat16(wa_ext);
        adapt_q <= adapt_en;
        acc_q   <= '0;
        k_q     <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        // Read-before-write: the MAC above used the old weight of this tap.
        if (adapt_q) begin
          w_q[k_q] <= w_upd;
        end
        k_q <= k_q + KW'(1);
      end
      if (state_q == DONE) begin
        fir_out_q  <= sat32(acc_shift);
        fir_done_q <= 1'b1;
      end
    end
  end

  assign fir_out  = fir_out_q;
  assign fir_done = fir_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lms_fir_engine.sv
// -----------------------------------------------------------------------------
// tb_lms_fir_engine
// Self-checking bench: a pass-level model (arrays of samples and weights,
// whole-pass arithmetic) predicts busy / fir_done / fir_out for every cycle,
// plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_lms_fir_engine;

  localparam int NTAPS = 16;
  localparam int LAT   = NTAPS + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               fir_go = 1'b0;
  logic               adapt_en = 1'b0;
  logic signed [31:0] sample_in = '0;
  logic signed [31:0] weight_adjust = '0;
  logic signed [31:0] fir_out;
  logic               fir_done;
  logic               busy;

  always #5 clk = ~clk;

  lms_fir_engine #(.NTAPS(NTAPS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fir_go        (fir_go),
    .sample_in     (sample_in),
    .weight_adjust (weight_adjust),
    .adapt_en      (adapt_en),
    .fir_out       (fir_out),
    .fir_done      (fir_done),
    .busy          (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  longint xm [NTAPS];
  longint wm [NTAPS];
  longint exp_out  = 0;
  longint pend_out = 0;
  int     edge_n   = 0;
  int     acc_n    = -1000;   // edge index of the most recent accept

  function automatic longint clamp(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(string name, longint got, longint expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      xm[k] = 0;
      wm[k] = 0;
    end
    exp_out  = 0;
    pend_out = 0;
    acc_n    = -1000;
  endtask

  // Whole pass evaluated at its accept edge; the result becomes visible
  // LAT edges later. Weights changed now only matter to later passes.
  task automatic model_edge();
    int     e;
    longint mu;
    longint acc;
    e = edge_n + 1;
    if (e == acc_n + LAT) exp_out = pend_out;
    if (fir_go && (e - acc_n >= LAT + 1)) begin
      for (int k = NTAPS - 1; k >= 1; k--) xm[k] = xm[k-1];
      xm[0] = clamp(longint'(sample_in), -32768, 32767);
      mu    = clamp(longint'(weight_adjust) >>> 15, -32768, 32767);
      acc   = 0;
      for (int k = 0; k < NTAPS; k++) begin
        acc += wm[k] * xm[k];
        if (adapt_en) wm[k] = clamp(wm[k] + ((mu * xm[k]) >>> 15), -32768, 32767);
      end
      pend_out = clamp(acc >>> 15, -64'sd2147483648, 64'sd2147483647);
      acc_n    = e;
    end
    edge_n = e;
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic step();
    int d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    d = edge_n - acc_n;
    check("busy",     longint'(busy),     longint'(d >= 0 && d <= LAT - 1));
    check("fir_done", longint'(fir_done), longint'(d == LAT));
    check("fir_out",  longint'(fir_out),  exp_out);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    check("rst_fir_out",  longint'(fir_out),  0);
    check("rst_fir_done", longint'(fir_done), 0);
    check("rst_busy",     longint'(busy),     0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept a pass, then run until its fir_done cycle.
  task automatic run_pass(input logic signed [31:0] s, input logic signed [31:0] wa,
                          input logic ad);
    sample_in     = s;
    weight_adjust = wa;
    adapt_en      = ad;
    fir_go        = 1'b1;
    step();
    fir_go = 1'b0;
    for (int i = 0; i < LAT; i++) step();
  endtask

  initial begin
    int lat;
    int cnt;
    model_reset();

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    check("por_fir_out",  longint'(fir_out),  0);
    check("por_fir_done", longint'(fir_done), 0);
    check("por_busy",     longint'(busy),     0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Latency with all-zero weights
    sample_in = 32'sd1234; weight_adjust = '0; adapt_en = 1'b1; fir_go = 1'b1;
    step();
    fir_go = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (fir_done) break;
    end
    check("latency", lat, 17);
    check("latency_out", longint'(fir_out), 0);
    step();

    // Reset in the middle of a pass, then a clean zero pass
    sample_in = 32'sd5000; weight_adjust = 32'sh2000_0000; adapt_en = 1'b1; fir_go = 1'b1;
    step();
    fir_go = 1'b0;
    for (int i = 0; i < 5; i++) step();
    async_reset();
    run_pass(32'sd0, 32'sd0, 1'b1);
    check("post_reset_out", longint'(fir_out), 0);

    // Two-pass adaptation: w[0] becomes 8192, second pass yields 4096
    run_pass(32'sd16384, 32'sh2000_0000, 1'b1);
    check("adapt_pass1", longint'(fir_out), 0);
    run_pass(32'sd16384, 32'sd0, 1'b1);
    check("adapt_pass2", longint'(fir_out), 4096);

    // Frozen pass with a stray fir_go pulse during MAC
    sample_in = 32'sd16384; weight_adjust = 32'sh2000_0000; adapt_en = 1'b0; fir_go = 1'b1;
    step();
    fir_go = 1'b0;
    for (int i = 0; i < 3; i++) step();
    sample_in = 32'sd32767; adapt_en = 1'b1; fir_go = 1'b1;
    step();
    fir_go = 1'b0;
    for (int i = 0; i < LAT - 4; i++) step();
    check("freeze_pass3", longint'(fir_out), 4096);
    run_pass(32'sd16384, 32'sd0, 1'b0);
    check("freeze_pass4", longint'(fir_out), 4096);

    // Weight saturation and sample clamping
    for (int p = 0; p < 10; p++) run_pass(32'sd32767, 32'sh3FFF_8000, 1'b1);
    run_pass(32'sd32767, 32'sd0, 1'b0);
    run_pass(32'sh0001_0000, 32'sd0, 1'b0);
    run_pass(-32'sd100000, 32'shC000_0000, 1'b1);
    run_pass(32'sd0, 32'sd0, 1'b0);

    // fir_go held high for 100 cycles
    cnt = 0;
    fir_go = 1'b1; sample_in = 32'sd1000; weight_adjust = 32'sh0100_0000; adapt_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fir_done) cnt++;
    end
    fir_go = 1'b0;
    check("held_done_count", cnt, 5);
    for (int i = 0; i < 20; i++) step();

    // Randomised traffic, inputs changing every cycle
    for (int i = 0; i < 600; i++) begin
      fir_go   = ($urandom_range(0, 3) == 0);
      adapt_en = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) sample_in = $urandom;
      else sample_in = 32'(signed'(16'($urandom)));
      if ($urandom_range(0, 3) == 0) weight_adjust = $urandom;
      else weight_adjust = 32'(signed'(16'($urandom))) <<< 13;
      step();
    end
    fir_go = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
